// File: rtl/branch_redirect_ctrl.sv
// Branch resolution sequencer: turns an accepted taken EX-stage control transfer into a
// one-cycle PC redirect plus wrong-path flush, or a misaligned-target trap, with statistics.
module branch_redirect_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid_i,
  input  logic             ex_is_branch_i,
  input  logic             ex_is_jump_i,
  input  logic             jump_en_i,
  input  logic [31:0]      ex_target_i,
  input  logic             stall_i,
  input  logic             cnt_clr_i,
  output logic             pc_redirect_o,
  output logic [31:0]      pc_target_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             kill_ex_o,
  output logic             trap_o,
  output logic [31:0]      trap_addr_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    TRAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  logic   accept;
  logic   taken;
  logic   aligned;
  logic   branch_inc;
  logic   taken_inc;

  // Only IDLE accepts; anything in EX while busy is wrong path.
  always_comb begin
    accept     = 1'b0;
    taken      = 1'b0;
    aligned    = 1'b0;
    branch_inc = 1'b0;
    taken_inc  = 1'b0;
    accept     = (state == IDLE) & ex_valid_i & (ex_is_branch_i | ex_is_jump_i) & ~stall_i;
    taken      = ex_is_jump_i | (ex_is_branch_i & jump_en_i);
    aligned    = (ex_target_i[1:0] == 2'b00);
    branch_inc = accept;
    taken_inc  = accept & taken & aligned;
  end

  // Saturating statistics; a clear beats a simultaneous increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_o <= '0;
      taken_cnt_o  <= '0;
    end else if (cnt_clr_i) begin
      branch_cnt_o <= '0;
      taken_cnt_o  <= '0;
    end else begin
      if (branch_inc && (branch_cnt_o != CNT_MAX)) begin
        branch_cnt_o <= branch_cnt_o + CNT_W'(1);
      end
      if (taken_inc && (taken_cnt_o != CNT_MAX)) begin
        taken_cnt_o <= taken_cnt_o + CNT_W'(1);
      end
    end
  end

  // Sequencer with registered strobes; a stall holds REDIR/TRAP unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc_redirect_o <= 1'b0;
      pc_target_o   <= '0;
      flush_if_id_o <= 1'b0;
      flush_id_ex_o <= 1'b0;
      kill_ex_o     <= 1'b0;
      trap_o        <= 1'b0;
      trap_addr_o   <= '0;
      busy_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && taken) begin
            flush_if_id_o <= 1'b1;
            flush_id_ex_o <= 1'b1;
            kill_ex_o     <= 1'b1;
            busy_o        <= 1'b1;
            if (aligned) begin
              state         <= REDIR;
              pc_redirect_o <= 1'b1;
              pc_target_o   <= ex_target_i;
            end else begin
              state         <= TRAP;
              trap_o        <= 1'b1;
              trap_addr_o   <= ex_target_i;
            end
          end
        end
        REDIR, TRAP: begin
          if (!stall_i) begin
            state         <= IDLE;
            pc_redirect_o <= 1'b0;
            flush_if_id_o <= 1'b0;
            flush_id_ex_o <= 1'b0;
            kill_ex_o     <= 1'b0;
            trap_o        <= 1'b0;
            busy_o        <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          pc_redirect_o <= 1'b0;
          flush_if_id_o <= 1'b0;
          flush_id_ex_o <= 1'b0;
          kill_ex_o     <= 1'b0;
          trap_o        <= 1'b0;
          busy_o        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized self-checking bench for branch_redirect_ctrl against a behavioural model;
// a second narrow-counter instance exercises counter saturation in few cycles.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_is_branch, ex_is_jump, jump_en, stall, cnt_clr;
  logic [31:0] ex_target;

  logic        pc_redirect, flush_if_id, flush_id_ex, kill_ex, trap, busy;
  logic [31:0] pc_target, trap_addr;
  logic [15:0] branch_cnt, taken_cnt;

  logic        s_pc_redirect, s_flush_if_id, s_flush_id_ex, s_kill_ex, s_trap, s_busy;
  logic [31:0] s_pc_target, s_trap_addr;
  logic [3:0]  s_branch_cnt, s_taken_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: 0 = free, 1 = redirecting, 2 = trapping
  int          m_mode;
  logic [31:0] m_target, m_trap;
  int          m_bc, m_tc, m_sbc, m_stc;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_is_branch_i(ex_is_branch),
    .ex_is_jump_i(ex_is_jump), .jump_en_i(jump_en), .ex_target_i(ex_target),
    .stall_i(stall), .cnt_clr_i(cnt_clr), .pc_redirect_o(pc_redirect),
    .pc_target_o(pc_target), .flush_if_id_o(flush_if_id), .flush_id_ex_o(flush_id_ex),
    .kill_ex_o(kill_ex), .trap_o(trap), .trap_addr_o(trap_addr), .busy_o(busy),
    .branch_cnt_o(branch_cnt), .taken_cnt_o(taken_cnt)
  );

  branch_redirect_ctrl #(.CNT_W(4)) u_small (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_is_branch_i(ex_is_branch),
    .ex_is_jump_i(ex_is_jump), .jump_en_i(jump_en), .ex_target_i(ex_target),
    .stall_i(stall), .cnt_clr_i(cnt_clr), .pc_redirect_o(s_pc_redirect),
    .pc_target_o(s_pc_target), .flush_if_id_o(s_flush_if_id), .flush_id_ex_o(s_flush_id_ex),
    .kill_ex_o(s_kill_ex), .trap_o(s_trap), .trap_addr_o(s_trap_addr), .busy_o(s_busy),
    .branch_cnt_o(s_branch_cnt), .taken_cnt_o(s_taken_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  function automatic int sat_inc(input int v, input int max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_target = '0; m_trap = '0;
    m_bc = 0; m_tc = 0; m_sbc = 0; m_stc = 0;
  endtask

  // Apply the rules to the inputs seen at the clock edge.
  task automatic model_update();
    bit is_cti, tk, al, acc;
    is_cti = ex_is_branch | ex_is_jump;
    tk     = ex_is_jump | (ex_is_branch & jump_en);
    al     = (ex_target[1:0] == 2'b00);
    acc    = (m_mode == 0) && ex_valid && is_cti && !stall;
    if (cnt_clr) begin
      m_bc = 0; m_tc = 0; m_sbc = 0; m_stc = 0;
    end else if (acc) begin
      m_bc  = sat_inc(m_bc, 65535);
      m_sbc = sat_inc(m_sbc, 15);
      if (tk && al) begin
        m_tc  = sat_inc(m_tc, 65535);
        m_stc = sat_inc(m_stc, 15);
      end
    end
    if (m_mode != 0) begin
      if (!stall) m_mode = 0;
    end else if (acc && tk) begin
      if (al) begin m_mode = 1; m_target = ex_target; end
      else    begin m_mode = 2; m_trap   = ex_target; end
    end
  endtask

  task automatic check_all();
    check("pc_redirect", 32'(pc_redirect), 32'(m_mode == 1));
    check("flush_if_id", 32'(flush_if_id), 32'(m_mode != 0));
    check("flush_id_ex", 32'(flush_id_ex), 32'(m_mode != 0));
    check("kill_ex",     32'(kill_ex),     32'(m_mode != 0));
    check("trap",        32'(trap),        32'(m_mode == 2));
    check("busy",        32'(busy),        32'(m_mode != 0));
    check("pc_target",   pc_target,        m_target);
    check("trap_addr",   trap_addr,        m_trap);
    check("branch_cnt",  32'(branch_cnt),  32'(m_bc));
    check("taken_cnt",   32'(taken_cnt),   32'(m_tc));
    check("s_branch_cnt", 32'(s_branch_cnt), 32'(m_sbc));
    check("s_taken_cnt",  32'(s_taken_cnt),  32'(m_stc));
    check("s_redirect",  32'(s_pc_redirect), 32'(m_mode == 1));
    check("s_trap",      32'(s_trap),        32'(m_mode == 2));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input bit br, input bit jp, input bit je,
                       input logic [31:0] tgt, input bit st, input bit clr);
    ex_valid = v; ex_is_branch = br; ex_is_jump = jp; jump_en = je;
    ex_target = tgt; stall = st; cnt_clr = clr;
  endtask

  task automatic idle_cycles(input int n);
    drive(0, 0, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 0, 0);
    model_reset();
    #12;
    check_all();
    @(negedge clk) rst_n = 1'b1;

    // BEQ taken to 0x100, then one-cycle redirect
    drive(1, 1, 0, 1, 32'h0000_0100, 0, 0); cycle();
    check("beq_redirect", 32'(pc_redirect), 32'd1);
    idle_cycles(2);

    // BNE not taken
    drive(1, 1, 0, 0, 32'h0000_0200, 0, 0); cycle();
    idle_cycles(1);

    // JAL to misaligned 0x102 -> trap
    drive(1, 0, 1, 0, 32'h0000_0102, 0, 0); cycle();
    check("jal_trap_addr", trap_addr, 32'h0000_0102);
    idle_cycles(2);

    // Both flags with jump_en low: jump wins, so taken
    drive(1, 1, 1, 0, 32'h0000_0400, 0, 0); cycle();
    idle_cycles(2);

    // Branch stalled 3 cycles then released; stall 2 cycles during REDIR
    drive(1, 1, 0, 1, 32'h0000_0800, 1, 0);
    for (int i = 0; i < 3; i++) cycle();
    drive(1, 1, 0, 1, 32'h0000_0800, 0, 0); cycle();
    drive(1, 1, 0, 1, 32'h0000_0c00, 1, 0); cycle(); cycle();
    drive(1, 1, 0, 1, 32'h0000_0c00, 0, 0); cycle();
    idle_cycles(2);

    // Taken branches until the narrow counters saturate
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0, 1, 32'h0000_1000 + 32'(i * 4), 0, 0); cycle();
      idle_cycles(1);
    end
    check("s_taken_sat", 32'(s_taken_cnt), 32'd15);

    // Clear together with an accept
    drive(1, 1, 0, 1, 32'h0000_2000, 0, 1); cycle();
    check("clr_accept", 32'(branch_cnt), 32'd0);
    idle_cycles(2);

    // Reset asserted mid-REDIR drops strobes immediately
    drive(1, 1, 0, 1, 32'h0000_3000, 0, 0); cycle();
    drive(0, 0, 0, 0, 32'h0, 1, 0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk) rst_n = 1'b1;
    idle_cycles(1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = $urandom();
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      drive(($urandom_range(0, 3) != 0), 1'($urandom()), ($urandom_range(0, 3) == 0),
            1'($urandom()), tgt, ($urandom_range(0, 3) == 0), ($urandom_range(0, 49) == 0));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
